// File: rtl/seg_scan_decoder.sv
// Recovers BCD digits from a multiplexed seven-segment bus: each digit slot is
// registered, qualified for stability, decoded and latched into a packed register.
module seg_scan_decoder #(
    parameter int DIGITS = 4,
    parameter int STABLE = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [6:0]          seg_in,
    input  logic [DIGITS-1:0]   dig_en,
    output logic [4*DIGITS-1:0] bcd_out,
    output logic [DIGITS-1:0]   digit_err,
    output logic                frame_valid
);
    localparam logic [3:0] STABLE_L = 4'(STABLE);

    logic [6:0]          r_s_seg;
    logic [DIGITS-1:0]   r_s_dig;
    logic [6:0]          r_prev_seg;
    logic [DIGITS-1:0]   r_prev_dig;
    logic [3:0]          r_run;
    logic                r_lock;
    logic [DIGITS-1:0]   r_seen;
    logic [4*DIGITS-1:0] r_bcd;
    logic [DIGITS-1:0]   r_err;
    logic                r_frame;

    logic                w_onehot;
    logic                w_same;
    logic                w_lock_base;
    logic                w_commit;
    logic [3:0]          w_run_nxt;
    logic [3:0]          w_nib;
    logic                w_bad;
    logic [DIGITS-1:0]   w_seen_nxt;

    // Commit fires on the edge where the run count becomes STABLE, so a window
    // held from before edge 1 lands its nibble at edge STABLE+1.
    always_comb begin
        w_onehot    = $onehot(r_s_dig);
        w_same      = (r_run != 4'd0) && (r_s_seg == r_prev_seg) && (r_s_dig == r_prev_dig);
        w_run_nxt   = 4'd0;
        w_lock_base = 1'b0;
        w_commit    = 1'b0;
        if (w_onehot) begin
            if (w_same) begin
                w_run_nxt   = (r_run >= STABLE_L) ? STABLE_L : r_run + 4'd1;
                w_lock_base = r_lock;
            end else begin
                w_run_nxt   = 4'd1;
            end
            w_commit = (w_run_nxt == STABLE_L) && !w_lock_base;
        end
        w_seen_nxt = r_seen | r_s_dig;
    end

    always_comb begin
        w_nib = 4'hF;
        w_bad = 1'b0;
        case (r_s_seg)
            7'h7E:   w_nib = 4'd0;
            7'h30:   w_nib = 4'd1;
            7'h6D:   w_nib = 4'd2;
            7'h79:   w_nib = 4'd3;
            7'h33:   w_nib = 4'd4;
            7'h5B:   w_nib = 4'd5;
            7'h5F:   w_nib = 4'd6;
            7'h70:   w_nib = 4'd7;
            7'h7F:   w_nib = 4'd8;
            7'h7B:   w_nib = 4'd9;
            7'h00:   w_nib = 4'hA;
            default: begin
                w_nib = 4'hF;
                w_bad = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s_seg    <= '0;
            r_s_dig    <= '0;
            r_prev_seg <= '0;
            r_prev_dig <= '0;
            r_run      <= '0;
            r_lock     <= 1'b0;
            r_seen     <= '0;
            r_bcd      <= '0;
            r_err      <= '0;
            r_frame    <= 1'b0;
        end else begin
            r_s_seg <= seg_in;
            r_s_dig <= dig_en;
            r_frame <= 1'b0;
            r_run   <= w_run_nxt;
            r_lock  <= w_lock_base | w_commit;
            if (w_onehot) begin
                r_prev_seg <= r_s_seg;
                r_prev_dig <= r_s_dig;
            end
            if (w_commit) begin
                for (int i = 0; i < DIGITS; i++) begin
                    if (r_s_dig[i]) begin
                        r_bcd[4*i +: 4] <= w_nib;
                        r_err[i]        <= w_bad;
                    end
                end
                // Completing the mask pulses the frame and opens the next one on the same edge.
                if (&w_seen_nxt) begin
                    r_frame <= 1'b1;
                    r_seen  <= '0;
                end else begin
                    r_seen  <= w_seen_nxt;
                end
            end
        end
    end

    assign bcd_out     = r_bcd;
    assign digit_err   = r_err;
    assign frame_valid = r_frame;
endmodule

// File: tb/tb_seg_scan_decoder.sv
// Self-checking bench for seg_scan_decoder: directed scenarios plus random scans
// checked against a run-of-identical-samples reference model.
module tb_seg_scan_decoder;
    localparam int DIGITS = 4;
    localparam int STABLE = 3;

    logic        clk;
    logic        rst;
    logic [6:0]  seg_in;
    logic [3:0]  dig_en;
    logic [15:0] bcd_out;
    logic [3:0]  digit_err;
    logic        frame_valid;

    seg_scan_decoder #(.DIGITS(DIGITS), .STABLE(STABLE)) dut (
        .clk         (clk),
        .rst         (rst),
        .seg_in      (seg_in),
        .dig_en      (dig_en),
        .bcd_out     (bcd_out),
        .digit_err   (digit_err),
        .frame_valid (frame_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int chk_cnt = 0;
    int pass_cnt = 0;
    int frames_seen = 0;

    logic [6:0] glyph [10] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70, 7'h7F, 7'h7B};

    // Reference model: a sample commits when it is the STABLE-th member of a
    // maximal run of identical one-hot samples, one edge after it is registered.
    logic [6:0]  m_pend_seg = '0;
    logic [3:0]  m_pend_dig = '0;
    logic [6:0]  m_last_seg = '0;
    logic [3:0]  m_last_dig = '0;
    int          m_cnt = 0;
    logic [3:0]  m_seen = '0;
    logic [15:0] exp_bcd = '0;
    logic [3:0]  exp_err = '0;
    logic        exp_frame = 1'b0;

    function automatic void model_decode(input logic [6:0] s, output logic [3:0] n, output logic e);
        n = 4'hF;
        e = 1'b1;
        if (s == 7'h00) begin
            n = 4'hA;
            e = 1'b0;
        end
        for (int k = 0; k < 10; k++) begin
            if (glyph[k] == s) begin
                n = 4'(k);
                e = 1'b0;
            end
        end
    endfunction

    task automatic step(input logic [6:0] seg, input logic [3:0] dig, input logic r);
        logic [3:0] n;
        logic       e;
        int         d;
        seg_in = seg;
        dig_en = dig;
        rst    = r;
        @(posedge clk);
        exp_frame = 1'b0;
        if (r) begin
            exp_bcd    = '0;
            exp_err    = '0;
            m_seen     = '0;
            m_cnt      = 0;
            m_pend_seg = '0;
            m_pend_dig = '0;
        end else begin
            if ($countones(m_pend_dig) == 1) begin
                if (m_cnt > 0 && m_pend_seg == m_last_seg && m_pend_dig == m_last_dig)
                    m_cnt++;
                else
                    m_cnt = 1;
                m_last_seg = m_pend_seg;
                m_last_dig = m_pend_dig;
                if (m_cnt == STABLE) begin
                    d = 0;
                    for (int k = 0; k < DIGITS; k++) if (m_pend_dig[k]) d = k;
                    model_decode(m_pend_seg, n, e);
                    exp_bcd[4*d +: 4] = n;
                    exp_err[d]        = e;
                    m_seen[d]         = 1'b1;
                    if (&m_seen) begin
                        exp_frame = 1'b1;
                        m_seen    = '0;
                    end
                end
            end else begin
                m_cnt = 0;
            end
            m_pend_seg = seg;
            m_pend_dig = dig;
        end
        #1;
        if (frame_valid) frames_seen++;
    endtask

    task automatic hold(input logic [6:0] seg, input logic [3:0] dig, input int n);
        repeat (n) step(seg, dig, 1'b0);
    endtask

    task automatic do_reset();
        repeat (2) step(7'($urandom_range(0, 127)), 4'($urandom_range(0, 15)), 1'b1);
    endtask

    task automatic test_reset();
        do_reset();
        chk_cnt++;
        if (bcd_out !== 16'h0) $display("FAIL reset_bcd actual=%h expected=%h", bcd_out, 16'h0); else pass_cnt++;
        chk_cnt++;
        if (digit_err !== 4'h0) $display("FAIL reset_err actual=%b expected=%b", digit_err, 4'h0); else pass_cnt++;
        chk_cnt++;
        if (frame_valid !== 1'b0) $display("FAIL reset_frame actual=%b expected=0", frame_valid); else pass_cnt++;
        for (int i = 1; i <= 6; i++) begin
            step(7'h6D, 4'b0010, 1'b0);
            chk_cnt++;
            if (bcd_out !== ((i >= 4) ? 16'h0020 : 16'h0000))
                $display("FAIL reset_latency_edge%0d actual=%h expected=%h", i, bcd_out, (i >= 4) ? 16'h0020 : 16'h0000);
            else pass_cnt++;
        end
    endtask

    task automatic test_clean_scan();
        logic [6:0] scan [4] = '{7'h79, 7'h30, 7'h33, 7'h30};
        do_reset();
        for (int pass = 0; pass < 2; pass++) begin
            frames_seen = 0;
            for (int d = 0; d < 3; d++) hold(scan[d], 4'(1 << d), 5);
            for (int i = 1; i <= 5; i++) begin
                step(scan[3], 4'b1000, 1'b0);
                if (pass == 0 && i >= 3 && i <= 4) begin
                    chk_cnt++;
                    if (bcd_out[15:12] !== ((i == 4) ? 4'h1 : 4'h0))
                        $display("FAIL scan_d3_edge%0d actual=%h expected=%h", i, bcd_out[15:12], (i == 4) ? 4'h1 : 4'h0);
                    else pass_cnt++;
                end
                if (i == 3 || i == 4) begin
                    chk_cnt++;
                    if (frame_valid !== (i == 4))
                        $display("FAIL scan_frame_edge%0d actual=%b expected=%b", i, frame_valid, (i == 4));
                    else pass_cnt++;
                end
            end
            chk_cnt++;
            if (bcd_out !== 16'h1413) $display("FAIL scan_bcd pass%0d actual=%h expected=%h", pass, bcd_out, 16'h1413); else pass_cnt++;
            chk_cnt++;
            if (frames_seen !== 1) $display("FAIL scan_frames pass%0d actual=%0d expected=1", pass, frames_seen); else pass_cnt++;
        end
    endtask

    task automatic test_illegal_blank();
        do_reset();
        frames_seen = 0;
        hold(7'h7E, 4'b0001, 5);
        hold(7'h01, 4'b0010, 5);
        hold(7'h00, 4'b0100, 5);
        hold(7'h79, 4'b1000, 5);
        chk_cnt++;
        if (bcd_out !== 16'h3AF0) $display("FAIL illegal_bcd actual=%h expected=%h", bcd_out, 16'h3AF0); else pass_cnt++;
        chk_cnt++;
        if (digit_err !== 4'b0010) $display("FAIL illegal_err actual=%b expected=%b", digit_err, 4'b0010); else pass_cnt++;
        hold(7'h7E, 4'b0001, 5);
        hold(7'h30, 4'b0010, 5);
        hold(7'h00, 4'b0100, 5);
        hold(7'h79, 4'b1000, 5);
        chk_cnt++;
        if (bcd_out !== 16'h3A10) $display("FAIL illegal_fix_bcd actual=%h expected=%h", bcd_out, 16'h3A10); else pass_cnt++;
        chk_cnt++;
        if (digit_err !== 4'b0000) $display("FAIL illegal_fix_err actual=%b expected=%b", digit_err, 4'b0000); else pass_cnt++;
        chk_cnt++;
        if (frames_seen !== 2) $display("FAIL illegal_frames actual=%0d expected=2", frames_seen); else pass_cnt++;
    endtask

    task automatic test_short_dwell();
        do_reset();
        hold(7'h30, 4'b0001, 2);
        hold(7'h55, 4'b0001, 1);
        for (int i = 1; i <= 4; i++) begin
            step(7'h7B, 4'b0001, 1'b0);
            chk_cnt++;
            if (bcd_out[3:0] !== ((i == 4) ? 4'h9 : 4'h0))
                $display("FAIL ghost_edge%0d actual=%h expected=%h", i, bcd_out[3:0], (i == 4) ? 4'h9 : 4'h0);
            else pass_cnt++;
        end
        hold(7'h00, 4'b0000, 3);
        chk_cnt++;
        if (bcd_out !== 16'h0009 || digit_err !== 4'h0)
            $display("FAIL ghost_final actual=%h/%b expected=%h/%b", bcd_out, digit_err, 16'h0009, 4'h0);
        else pass_cnt++;
    endtask

    task automatic test_invalid_enables();
        do_reset();
        hold(7'h5F, 4'b0100, 2);
        hold(7'h5F, 4'b0000, 10);
        hold(7'h5F, 4'b0110, 10);
        chk_cnt++;
        if (bcd_out !== 16'h0 || digit_err !== 4'h0)
            $display("FAIL inv_no_commit actual=%h/%b expected=%h/%b", bcd_out, digit_err, 16'h0, 4'h0);
        else pass_cnt++;
        for (int i = 1; i <= 4; i++) begin
            step(7'h5F, 4'b0100, 1'b0);
            chk_cnt++;
            if (bcd_out[11:8] !== ((i == 4) ? 4'h6 : 4'h0))
                $display("FAIL inv_latency_edge%0d actual=%h expected=%h", i, bcd_out[11:8], (i == 4) ? 4'h6 : 4'h0);
            else pass_cnt++;
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        hold(7'h7E, 4'b0001, 5);
        hold(7'h30, 4'b0010, 5);
        do_reset();
        frames_seen = 0;
        hold(7'h6D, 4'b0100, 5);
        hold(7'h79, 4'b1000, 5);
        chk_cnt++;
        if (frames_seen !== 0) $display("FAIL midrst_partial actual=%0d expected=0", frames_seen); else pass_cnt++;
        hold(7'h33, 4'b0001, 5);
        hold(7'h5B, 4'b0010, 5);
        chk_cnt++;
        if (frames_seen !== 1) $display("FAIL midrst_full actual=%0d expected=1", frames_seen); else pass_cnt++;
        chk_cnt++;
        if (bcd_out !== 16'h3254) $display("FAIL midrst_bcd actual=%h expected=%h", bcd_out, 16'h3254); else pass_cnt++;
    endtask

    task automatic test_random();
        logic [6:0] seg;
        logic [3:0] dig;
        int         dwell;
        int         bad;
        do_reset();
        bad = 0;
        for (int w = 0; w < 300; w++) begin
            if ($urandom_range(0, 99) < 85) dig = 4'(1 << $urandom_range(0, 3));
            else                            dig = 4'($urandom_range(0, 15));
            case ($urandom_range(0, 19))
                0, 1, 2:         seg = 7'h00;
                3, 4, 5, 6, 7, 8: seg = 7'($urandom_range(0, 127));
                default:         seg = glyph[$urandom_range(0, 9)];
            endcase
            dwell = $urandom_range(1, 6);
            for (int c = 0; c < dwell; c++) begin
                step(seg, dig, ($urandom_range(0, 299) == 0));
                chk_cnt++;
                if (bcd_out !== exp_bcd || digit_err !== exp_err || frame_valid !== exp_frame) begin
                    if (bad < 10)
                        $display("FAIL random_w%0d actual=%h/%b/%b expected=%h/%b/%b", w,
                                 bcd_out, digit_err, frame_valid, exp_bcd, exp_err, exp_frame);
                    bad++;
                end else pass_cnt++;
            end
        end
    endtask

    initial begin
        rst    = 1'b1;
        seg_in = '0;
        dig_en = '0;
        test_reset();
        test_clean_scan();
        test_illegal_blank();
        test_short_dwell();
        test_invalid_enables();
        test_mid_reset();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
